// File: rtl/sequence_display_ctrl_if.sv
// Bus between the game control unit, the sequence memory and the playback sequencer.
// The master side drives the control and memory data; the slave is the sequencer.
interface sequence_display_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] limite;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] leds;
    logic              busy;
    logic              done;
    logic [3:0]        db_estado;

    modport master (
        output start, abort, limite, mem_data,
        input  addr, leds, busy, done, db_estado
    );

    modport slave (
        input  start, abort, limite, mem_data,
        output addr, leds, busy, done, db_estado
    );
endinterface

// File: rtl/sequence_display_ctrl.sv
// Plays back the stored move sequence of the current round on the LEDs, one item at a
// time with a blank gap after each, then pulses done for the main game FSM.
module sequence_display_ctrl #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned ON_CYCLES  = 1000,
    parameter int unsigned OFF_CYCLES = 500
) (
    input logic                    clock,
    input logic                    reset,
    sequence_display_ctrl_if.slave bus
);
    localparam int unsigned MaxCycles = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [TimerW-1:0] OnLast  = TimerW'(ON_CYCLES - 1);
    localparam logic [TimerW-1:0] OffLast = TimerW'(OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StShow = 3'd2,
        StGap  = 3'd3,
        StNext = 3'd4,
        StDone = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  limit_q, limit_d;
    logic [TimerW-1:0]  timer_q, timer_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            limit_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            limit_q <= limit_d;
            timer_q <= timer_d;
        end
    end

    // addr moves on the transition into LOAD/NEXT so the memory word is ready for SHOW.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        limit_d = limit_q;
        timer_d = timer_q;
        if (bus.abort) begin
            state_d = StIdle;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StLoad;
                        limit_d = bus.limite;
                        addr_d  = '0;
                        timer_d = '0;
                    end
                end
                StLoad: begin
                    state_d = StShow;
                    addr_d  = '0;
                    timer_d = '0;
                end
                StShow: begin
                    if (timer_q == OnLast) begin
                        timer_d = '0;
                        state_d = StGap;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StGap: begin
                    if (timer_q == OffLast) begin
                        timer_d = '0;
                        if (addr_q == limit_q) begin
                            state_d = StDone;
                        end else begin
                            state_d = StNext;
                            addr_d  = addr_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StNext:  state_d = StShow;
                StDone:  state_d = StIdle;
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.addr      = addr_q;
        bus.leds      = '0;
        bus.busy      = (state_q != StIdle);
        bus.done      = 1'b0;
        bus.db_estado = 4'hF;
        unique case (state_q)
            StIdle:  bus.db_estado = 4'd0;
            StLoad:  bus.db_estado = 4'd1;
            StShow: begin
                bus.db_estado = 4'd2;
                bus.leds      = bus.mem_data;
            end
            StGap:   bus.db_estado = 4'd3;
            StNext:  bus.db_estado = 4'd4;
            StDone: begin
                bus.db_estado = 4'd5;
                bus.done      = 1'b1;
            end
            default: bus.db_estado = 4'hF;
        endcase
    end
endmodule

// File: tb/tb_sequence_display_ctrl.sv
// Self-checking bench for sequence_display_ctrl with ON_CYCLES=3, OFF_CYCLES=2; expected
// per-cycle outputs are generated from the playback rules into a queue and popped each cycle.
module tb_sequence_display_ctrl;
    localparam int On  = 3;
    localparam int Off = 2;

    typedef struct {
        int lim;
        int pat;
        int done_cyc;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] mem [16];
    logic [13:0] exp_q [$];
    int n_checks = 0;
    int n_err    = 0;
    int rc       = 0;

    sequence_display_ctrl_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    sequence_display_ctrl #(
        .ADDR_W(4), .DATA_W(4), .ON_CYCLES(On), .OFF_CYCLES(Off)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    assign bus.mem_data = mem[bus.addr];

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog rc=%0d got=timeout want=finish", rc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s rc=%0d got=%h want=%h", name, rc, got, want);
        end
    endtask

    function automatic logic [13:0] act();
        return {bus.addr, bus.leds, bus.busy, bus.done, bus.db_estado};
    endfunction

    function automatic void push(input logic [3:0] a, input logic [3:0] l, input logic b,
                                 input logic d, input logic [3:0] s);
        exp_q.push_back({a, l, b, d, s});
    endfunction

    // Expected trace from LOAD (cycle 1) through the IDLE cycle after DONE.
    function automatic void gen_run(input int lim);
        push(4'd0, 4'd0, 1'b1, 1'b0, 4'd1);
        for (int i = 0; i <= lim; i++) begin
            for (int k = 0; k < On; k++) push(4'(i), mem[i], 1'b1, 1'b0, 4'd2);
            for (int k = 0; k < Off; k++) push(4'(i), 4'd0, 1'b1, 1'b0, 4'd3);
            if (i < lim) push(4'(i + 1), 4'd0, 1'b1, 1'b0, 4'd4);
            else         push(4'(lim), 4'd0, 1'b1, 1'b1, 4'd5);
        end
        push(4'(lim), 4'd0, 1'b0, 1'b0, 4'd0);
    endfunction

    task automatic fill_mem(input int pat);
        for (int i = 0; i < 16; i++) begin
            case (pat)
                0:       mem[i] = 4'(i);
                1:       mem[i] = 4'(1 << (i % 4));
                default: mem[i] = 4'($urandom_range(0, 15));
            endcase
        end
    endtask

    task automatic do_run(input int lim, input int exp_done, input string name);
        int done_at;
        logic [13:0] e;
        exp_q.delete();
        gen_run(lim);
        bus.limite = 4'(lim);
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        rc        = 1;
        done_at   = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.done) done_at = rc;
            check(name, 32'(act()), 32'(e));
            tick();
            rc++;
        end
        check({name, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    endtask

    vec_t vecs [4];

    initial begin
        logic [13:0] e;
        int done_at;
        vecs[0] = '{lim: 0,  pat: 1, done_cyc: 7};
        vecs[1] = '{lim: 2,  pat: 1, done_cyc: 19};
        vecs[2] = '{lim: 5,  pat: 2, done_cyc: 37};
        vecs[3] = '{lim: 15, pat: 0, done_cyc: 97};

        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.limite = 4'd0;
        fill_mem(1);
        #1;
        check("reset_state", 32'(act()), 32'(0));
        #12;
        reset = 1'b0;
        tick();
        check("idle_after_reset", 32'(act()), 32'(0));

        for (int v = 0; v < 4; v++) begin
            fill_mem(vecs[v].pat);
            do_run(vecs[v].lim, vecs[v].done_cyc, $sformatf("run_lim%0d", vecs[v].lim));
        end

        // start re-pulsed and held, limite changed mid-run: only the latched limit counts.
        fill_mem(2);
        exp_q.delete();
        gen_run(1);
        push(4'd0, 4'd0, 1'b1, 1'b0, 4'd1);
        bus.limite = 4'd1;
        bus.start  = 1'b1;
        tick();
        rc      = 1;
        done_at = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.done) done_at = rc;
            check("ignored_inputs", 32'(act()), 32'(e));
            if (rc == 1) bus.start = 1'b0;
            if (rc == 5) bus.start = 1'b1;
            if (rc == 6) bus.limite = 4'd3;
            if (rc == 15) begin
                bus.start = 1'b0;
                bus.abort = 1'b1;
            end
            tick();
            rc++;
        end
        check("ignored_done_cycle", 32'(done_at), 32'(13));
        check("abort_from_load", 32'(act()), 32'({4'd0, 4'd0, 1'b0, 1'b0, 4'd0}));
        bus.abort = 1'b0;
        tick();

        // Abort during SHOW of addr 1.
        fill_mem(1);
        exp_q.delete();
        gen_run(2);
        bus.limite = 4'd2;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        rc        = 1;
        done_at   = -1;
        while (rc <= 9) begin
            e = exp_q.pop_front();
            if (bus.done) done_at = rc;
            check("abort_prefix", 32'(act()), 32'(e));
            if (rc == 9) bus.abort = 1'b1;
            tick();
            rc++;
        end
        check("abort_idle", 32'(act()), 32'({4'd1, 4'd0, 1'b0, 1'b0, 4'd0}));
        check("abort_no_done", 32'(done_at), 32'(-1));
        bus.abort = 1'b0;
        tick();
        check("abort_stays_idle", 32'(act()), 32'({4'd1, 4'd0, 1'b0, 1'b0, 4'd0}));
        do_run(2, 19, "rerun_after_abort");

        // Asynchronous reset mid-run, away from any clock edge.
        exp_q.delete();
        bus.limite = 4'd2;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rc = 8;
        check("pre_reset_show", 32'(act()), 32'({4'd1, mem[1], 1'b1, 1'b0, 4'd2}));
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", 32'(act()), 32'(0));
        #2;
        reset = 1'b0;
        tick();
        check("idle_after_async_reset", 32'(act()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
